// File: rtl/pio_in_pkg.sv
// rtl/pio_in_pkg.sv - register addresses and edge-mode type for the input PIO
package pio_in_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISING  = 2'd0,
    EDGE_FALLING = 2'd1,
    EDGE_ANY     = 2'd2
  } edge_mode_t;

endpackage

// File: rtl/pio_in_filter.sv
// rtl/pio_in_filter.sv - one-pin synchroniser plus debounce filter
module pio_in_filter #(
  parameter int DEBOUNCE_CYCLES = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_pin,
  output logic filt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Two-flop synchroniser, then filt follows sync2 only after it has
  // disagreed with filt for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      filt  <= 1'b0;
    end else begin
      sync1 <= in_pin;
      sync2 <= sync1;
      if (sync2 == filt) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        filt <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pio_input_irq.sv
// rtl/pio_input_irq.sv - Avalon-MM input PIO with edge capture and masked IRQ
module pio_input_irq
  import pio_in_pkg::*;
#(
  parameter int         WIDTH           = 3,
  parameter int         DEBOUNCE_CYCLES = 1,
  parameter edge_mode_t EDGE_MODE       = EDGE_ANY
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] filt_d;
  logic [WIDTH-1:0] edge_evt;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] clr;
  logic [31:0]      rd_next;
  logic             wr_en;
  logic             unused_wdata;

  // Upper write-data bits are architecturally ignored.
  assign unused_wdata = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_filt
    pio_in_filter #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_filt (
      .clk    (clk),
      .reset_n(reset_n),
      .in_pin (in_port[i]),
      .filt   (filt[i])
    );
  end

  assign wr_en = chipselect & ~write_n;
  assign clr   = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

  // Previous filtered value for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) filt_d <= '0;
    else          filt_d <= filt;
  end

  // Select which filtered transitions count as events.
  always_comb begin
    edge_evt = '0;
    case (EDGE_MODE)
      EDGE_RISING:  edge_evt = filt & ~filt_d;
      EDGE_FALLING: edge_evt = ~filt & filt_d;
      default:      edge_evt = filt ^ filt_d;
    endcase
  end

  // Edge capture: write-1-to-clear, a same-cycle event overrides the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) edgecap <= '0;
    else          edgecap <= (edgecap & ~clr) | edge_evt;
  end

  // Interrupt mask register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                              irqmask <= '0;
    else if (wr_en && address == ADDR_IRQMASK) irqmask <= writedata[WIDTH-1:0];
  end

  // Read mux; unused upper bits and the reserved word read as zero.
  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA:    rd_next[WIDTH-1:0] = filt;
      ADDR_IRQMASK: rd_next[WIDTH-1:0] = irqmask;
      ADDR_EDGECAP: rd_next[WIDTH-1:0] = edgecap;
      default:      rd_next = '0;
    endcase
  end

  // Registered read data, updated every cycle regardless of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_next;
  end

  assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_pio_input_irq.sv
// tb/tb_pio_input_irq.sv - directed self-checking bench for pio_input_irq
module tb_pio_input_irq;
  import pio_in_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        cs_a;
  logic        cs_b;
  logic        write_n;
  logic [31:0] writedata;
  logic [2:0]  in_a;
  logic [2:0]  in_b;
  logic [31:0] readdata_a;
  logic [31:0] readdata_b;
  logic        irq_a;
  logic        irq_b;

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] da;
  logic [31:0] db;

  always #5 clk = ~clk;

  pio_input_irq #(
    .WIDTH(3), .DEBOUNCE_CYCLES(4), .EDGE_MODE(EDGE_ANY)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_a),
    .write_n(write_n), .writedata(writedata), .in_port(in_a),
    .readdata(readdata_a), .irq(irq_a)
  );

  pio_input_irq #(
    .WIDTH(3), .DEBOUNCE_CYCLES(1), .EDGE_MODE(EDGE_FALLING)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_b),
    .write_n(write_n), .writedata(writedata), .in_port(in_b),
    .readdata(readdata_b), .irq(irq_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] ra, output logic [31:0] rb);
    address = a;
    write_n = 1'b1;
    tick(1);
    ra = readdata_a;
    rb = readdata_b;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic sa, input logic sb);
    address   = a;
    writedata = d;
    cs_a      = sa;
    cs_b      = sb;
    write_n   = 1'b0;
    tick(1);
    write_n   = 1'b1;
    cs_a      = 1'b0;
    cs_b      = 1'b0;
    writedata = '0;
  endtask

  initial begin
    reset_n = 1'b0; address = 2'd0; cs_a = 1'b0; cs_b = 1'b0;
    write_n = 1'b1; writedata = '0; in_a = 3'b000; in_b = 3'b000;
    tick(3);
    reset_n = 1'b1;
    tick(1);

    // Reset state of every address
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), da, db);
      check($sformatf("reset_rd%0d", i), da, 32'h0);
    end
    check("reset_irq_a", {31'd0, irq_a}, 32'd1 - 32'd1);
    check("reset_irq_b", {31'd0, irq_b}, 32'h0);

    // Reserved word and upper mask bits ignore writes
    wr(2'd1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    rd(2'd1, da, db);
    check("reserved_rd", da, 32'h0);
    wr(ADDR_DATA, 32'hFFFF_FFFF, 1'b1, 1'b0);
    rd(ADDR_DATA, da, db);
    check("data_ro", da, 32'h0);
    wr(ADDR_IRQMASK, 32'hFFFF_FFFF, 1'b1, 1'b0);
    rd(ADDR_IRQMASK, da, db);
    check("irqmask_rd", da, 32'h7);

    // Debounce latency: filt at k+5, readdata/EDGECAP at k+6
    address = ADDR_DATA;
    in_a = 3'b101;
    tick(6);
    check("data_k5", readdata_a, 32'h0);
    check("irq_k5", {31'd0, irq_a}, 32'h0);
    tick(1);
    check("data_k6", readdata_a, 32'h5);
    check("irq_k6", {31'd0, irq_a}, 32'h1);
    rd(ADDR_EDGECAP, da, db);
    check("edgecap_101", da, 32'h5);

    // Write-1-to-clear
    wr(ADDR_EDGECAP, 32'h1, 1'b1, 1'b0);
    rd(ADDR_EDGECAP, da, db);
    check("w1c_bit0", da, 32'h4);
    check("w1c_irq_on", {31'd0, irq_a}, 32'h1);
    wr(ADDR_EDGECAP, 32'h4, 1'b1, 1'b0);
    rd(ADDR_EDGECAP, da, db);
    check("w1c_bit2", da, 32'h0);
    check("w1c_irq_off", {31'd0, irq_a}, 32'h0);

    // Return pins low and clear the resulting falling-edge captures
    in_a = 3'b000;
    tick(10);
    wr(ADDR_EDGECAP, 32'h7, 1'b1, 1'b0);

    // Glitch rejection: 3-cycle pulse is dropped
    in_a = 3'b001;
    tick(3);
    in_a = 3'b000;
    tick(12);
    rd(ADDR_DATA, da, db);
    check("glitch3_data", da, 32'h0);
    rd(ADDR_EDGECAP, da, db);
    check("glitch3_edgecap", da, 32'h0);

    // 4-cycle pulse passes the filter
    in_a = 3'b001;
    tick(4);
    in_a = 3'b000;
    tick(15);
    rd(ADDR_EDGECAP, da, db);
    check("pulse4_edgecap", da, 32'h1);
    wr(ADDR_EDGECAP, 32'h7, 1'b1, 1'b0);

    // Set beats clear: bit-1 event captured on the same edge as its clear
    in_a = 3'b010;
    tick(6);
    wr(ADDR_EDGECAP, 32'h2, 1'b1, 1'b0);
    rd(ADDR_EDGECAP, da, db);
    check("set_beats_clr", da, 32'h2);

    // Falling-edge mode with IRQMASK=010 on the second instance
    wr(ADDR_IRQMASK, 32'h2, 1'b0, 1'b1);
    in_b = 3'b010;
    tick(6);
    rd(ADDR_EDGECAP, da, db);
    check("fall_rise1", db, 32'h0);
    in_b = 3'b011;
    tick(6);
    in_b = 3'b010;
    tick(6);
    rd(ADDR_EDGECAP, da, db);
    check("fall_bit0", db, 32'h1);
    check("fall_bit0_irq", {31'd0, irq_b}, 32'h0);
    in_b = 3'b000;
    tick(6);
    rd(ADDR_EDGECAP, da, db);
    check("fall_bit1", db, 32'h3);
    check("fall_bit1_irq", {31'd0, irq_b}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pio_input_irq.md
# pio_input_irq

Parametrised Avalon-MM input PIO slave: WIDTH external pins are synchronised, debounced, edge-detected and latched into a write-1-to-clear edge-capture register. A per-bit interrupt mask gates a level IRQ to the processor. It sits on the system interconnect next to the other PIO slaves and supersedes the fixed 3-bit, data-only input port.

## Interface
- WIDTH, 3: number of input pins, 1..32.
- DEBOUNCE_CYCLES, 1: consecutive stable cycles required before the filtered value changes, 1..65535; 1 means plain one-flop retiming.
- EDGE_MODE, EDGE_ANY: EDGE_RISING, EDGE_FALLING or EDGE_ANY; selects which filtered transitions set edge-capture bits.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- address  in  2  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous external pins.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt, active-high.

## Operation
- Register map:
  - 0 DATA (RO): filtered pin value.
  - 1 reserved: reads 0.
  - 2 IRQMASK (RW): WIDTH bits.
  - 3 EDGECAP (R/W1C).
- Writes to addresses 0 and 1 are ignored. Bits [31:WIDTH] read 0 and ignore writes.
- Per bit, the input path is:
  - 2-flop synchroniser: sync1, sync2.
  - Debounce counter cnt, width clog2(DEBOUNCE_CYCLES+1).
  - Filtered flop filt.
  - Previous-value flop filt_d.
- Debounce rules, evaluated each cycle:
  - If sync2 == filt, cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1, filt <= sync2 and cnt <= 0.
  - Else cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches filt.
- Edge detection: filt_d <= filt every cycle. Edge event per bit:
  - RISING: filt & ~filt_d.
  - FALLING: ~filt & filt_d.
  - ANY: filt ^ filt_d.
- EDGECAP bit update: bit <= (bit & ~clr) | event, where clr = write to address 3 with writedata bit set. If an event and a clear hit the same bit in the same cycle, the event wins and the bit stays 1.
- irq = |(EDGECAP & IRQMASK), a combinational OR of flops with no extra latency.
- readdata is updated every clock from the address mux, independent of chipselect. Read side effects: none.
- Reset values, all zero: sync1, sync2, cnt, filt, filt_d, IRQMASK, EDGECAP, readdata, irq.
- A pin held high through reset release produces a rising/any event once it propagates. This is intended; software clears EDGECAP after init.

## Timing
- In the cases below, in_port changes between edges k-1 and k, and D = DEBOUNCE_CYCLES.
- Pin path:
  - sync1 updates at edge k, sync2 at k+1.
  - filt updates at k+1+D (input held stable).
  - EDGECAP bit sets at k+2+D; irq high in the following cycle if masked in.
  - DATA read: address presented in the cycle after edge k+1+D returns the new value on readdata after edge k+2+D.
- Read latency: 1 cycle (address at edge n sampled, readdata valid after edge n).
- IRQMASK and EDGECAP writes take effect at the sampling edge; irq reflects them in the next cycle.
- An asynchronous reset mid-debounce discards counts; no event is produced for the interrupted transition.

## Structure
- Package pio_in_pkg holds:
  - Address constants ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3.
  - The edge_mode_t enum (EDGE_RISING, EDGE_FALLING, EDGE_ANY).
- Sub-module pio_in_filter is one bit of synchroniser + debounce + filt, output filt. It is instantiated WIDTH times in a generate loop.
- Top level holds edge detect, EDGECAP, IRQMASK, read mux and irq.

## Test plan
- Reset, all addresses: with WIDTH=3, in_port=0, read all four addresses -> 0, 0, 0, 0; irq=0.
- Debounce and edge capture: WIDTH=3, D=4, EDGE_ANY, IRQMASK=3'b111; drive in_port 3'b000->3'b101 at edge k. Required response:
  - DATA=3'b101 from edge k+6.
  - EDGECAP=3'b101 at edge k+6.
  - irq=1.
- Glitch rejection: D=4, pulse bit 0 high for 3 cycles -> DATA bit 0 stays 0 and EDGECAP stays 0. A 4-cycle pulse -> EDGECAP[0]=1.
- Write-1-to-clear: EDGECAP=3'b101, write 3'b001 to address 3 -> EDGECAP=3'b100, irq stays 1. Then write 3'b100 -> EDGECAP=0, irq=0.
- Set beats clear: schedule a bit-1 event and a write of 3'b010 to address 3 on the same edge -> EDGECAP[1]=1 afterwards.
- Mode and mask: EDGE_FALLING, IRQMASK=3'b010.
  - Rising on bit 1 -> no capture.
  - Falling on bit 0 -> EDGECAP[0]=1 with irq=0.
  - Falling on bit 1 -> irq=1.
